// File: rtl/booth_ctrl.sv
// -----------------------------------------------------------------------------
// booth_ctrl -- control FSM for a radix-2 Booth multiplier.
//
// Drives the strobes of an external {A, Q, Q[-1]} datapath. The host puts the
// multiplicand on a shared operand bus during LOAD_M and the multiplier during
// LOAD_Q. The FSM then runs N EVAL/SHIFT pairs and pulses done for one cycle.
//
// Ports:
//   clk     rising-edge clock
//   rst     synchronous reset, active high (has priority over start)
//   start   begin request, only sampled in IDLE
//   q0      LSB of the datapath Q register
//   qm1     datapath Q[-1] flop
//   ldM     load multiplicand register from the operand bus
//   ldQ     load multiplier register from the operand bus
//   clrA    clear accumulator A
//   clrff   clear the Q[-1] flop
//   ldA     load A with the adder/subtractor result (combinational)
//   addsub  1 = A+M, 0 = A-M; only meaningful while ldA=1 (combinational)
//   sft     arithmetic right shift of {A, Q, Q[-1]}
//   busy    high in every state except IDLE
//   done    one-cycle completion pulse
//   cnt     remaining iteration count
// -----------------------------------------------------------------------------
module booth_ctrl #(
    parameter int N = 16
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 start,
    input  logic                 q0,
    input  logic                 qm1,
    output logic                 ldM,
    output logic                 ldQ,
    output logic                 clrA,
    output logic                 clrff,
    output logic                 ldA,
    output logic                 addsub,
    output logic                 sft,
    output logic                 busy,
    output logic                 done,
    output logic [$clog2(N):0]   cnt
);

    localparam int CW = $clog2(N) + 1;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_LOAD_M = 3'd1,
        ST_LOAD_Q = 3'd2,
        ST_EVAL   = 3'd3,
        ST_SHIFT  = 3'd4,
        ST_DONE   = 3'd5
    } state_t;

    state_t state_reg;
    state_t state_next;

    // Next-state decode. The Moore strobes below are registered from
    // state_next, so they line up with state_reg in the following cycle.
    always_comb begin
        state_next = state_reg;
        unique case (state_reg)
            ST_IDLE:   if (start) state_next = ST_LOAD_M;
            ST_LOAD_M: state_next = ST_LOAD_Q;
            ST_LOAD_Q: state_next = ST_EVAL;
            ST_EVAL:   state_next = ST_SHIFT;
            ST_SHIFT:  state_next = (cnt == CW'(1)) ? ST_DONE : ST_EVAL;
            ST_DONE:   state_next = ST_IDLE;
            default:   state_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg <= ST_IDLE;
            cnt       <= '0;
            ldM       <= 1'b0;
            ldQ       <= 1'b0;
            clrA      <= 1'b0;
            clrff     <= 1'b0;
            sft       <= 1'b0;
            busy      <= 1'b0;
            done      <= 1'b0;
        end else begin
            state_reg <= state_next;

            // Counter is loaded leaving LOAD_Q and decremented leaving SHIFT.
            // The last SHIFT sees cnt==1, so it lands on 0 entering DONE and
            // stays there through IDLE; it can never wrap.
            if (state_reg == ST_LOAD_Q) begin
                cnt <= CW'(N);
            end else if (state_reg == ST_SHIFT) begin
                cnt <= cnt - CW'(1);
            end

            ldM   <= (state_next == ST_LOAD_M);
            clrA  <= (state_next == ST_LOAD_M);
            clrff <= (state_next == ST_LOAD_M);
            ldQ   <= (state_next == ST_LOAD_Q);
            sft   <= (state_next == ST_SHIFT);
            done  <= (state_next == ST_DONE);
            busy  <= (state_next != ST_IDLE);
        end
    end

    // Booth recoding of {q0, qm1}: 10 -> subtract M, 01 -> add M, else no-op.
    // These depend on the live datapath bits, so they cannot be registered.
    always_comb begin
        ldA    = (state_reg == ST_EVAL) && (q0 ^ qm1);
        addsub = (state_reg == ST_EVAL) && !q0 && qm1;
    end

endmodule

// File: tb/tb_booth_ctrl.sv
module tb_booth_ctrl;

    localparam int N  = 16;
    localparam int CW = $clog2(N) + 1;

    logic          clk = 1'b0;
    logic          rst;
    logic          start;
    logic          q0;
    logic          qm1;
    logic          ldM, ldQ, clrA, clrff, ldA, addsub, sft, busy, done;
    logic [CW-1:0] cnt;

    booth_ctrl #(.N(N)) dut (
        .clk    (clk),
        .rst    (rst),
        .start  (start),
        .q0     (q0),
        .qm1    (qm1),
        .ldM    (ldM),
        .ldQ    (ldQ),
        .clrA   (clrA),
        .clrff  (clrff),
        .ldA    (ldA),
        .addsub (addsub),
        .sft    (sft),
        .busy   (busy),
        .done   (done),
        .cnt    (cnt)
    );

    always #5 clk = ~clk;

    int edges = 0;
    always @(posedge clk) edges <= edges + 1;

    // Behavioural datapath. A carries a guard bit so that subtracting the
    // most negative multiplicand does not overflow.
    logic [15:0] bus;
    logic [15:0] m_reg;
    logic [15:0] q_reg;
    logic [16:0] a_reg;
    logic        qm1_reg;
    logic        ovr, ovr_q0, ovr_qm1;

    assign q0  = ovr ? ovr_q0  : q_reg[0];
    assign qm1 = ovr ? ovr_qm1 : qm1_reg;

    always @(posedge clk) begin
        if (ldM)   m_reg   <= bus;
        if (ldQ)   q_reg   <= bus;
        if (clrA)  a_reg   <= '0;
        if (clrff) qm1_reg <= 1'b0;
        if (ldA)   a_reg   <= addsub ? a_reg + {m_reg[15], m_reg}
                                     : a_reg - {m_reg[15], m_reg};
        if (sft)   {a_reg, q_reg, qm1_reg} <= {a_reg[16], a_reg, q_reg};
    end

    // Scoreboard
    typedef struct {
        int          edge_no;
        logic [31:0] prod;
        bit          chk_prod;
        bit          chk_counts;
    } exp_t;

    exp_t sb[$];
    exp_t cur;
    int   checks = 0;
    int   errors = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s got %h expected %h (edge %0d)", name, act, exp, edges);
        end
    endtask

    // Monitor: per-cycle invariants plus scoreboard pop on every done.
    int            sft_cnt = 0;
    int            lda_cnt = 0;
    logic [CW-1:0] prev_cnt = '0;
    logic          prev_busy = 1'b0;
    logic          prev_ldq = 1'b0;

    always @(negedge clk) begin
        if (rst !== 1'b1) begin
            check("onehot", {31'd0, ($countones({ldM, ldQ, ldA, sft}) <= 1)}, 32'd1);
            if (busy && prev_busy && !prev_ldq)
                check("cnt_mono", {31'd0, (cnt <= prev_cnt)}, 32'd1);
        end
        if (ldM) begin
            sft_cnt = 0;
            lda_cnt = 0;
        end
        if (sft) sft_cnt++;
        if (ldA) lda_cnt++;
        if (done) begin
            if (sb.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL done_unexpected got done=1 at edge %0d required no done", edges);
            end else begin
                cur = sb.pop_front();
                check("done_edge", edges, cur.edge_no);
                check("busy_at_done", {31'd0, busy}, 32'd1);
                check("cnt_at_done", {{(32-CW){1'b0}}, cnt}, 32'd0);
                if (cur.chk_prod)
                    check("product", {a_reg[15:0], q_reg}, cur.prod);
                if (cur.chk_counts) begin
                    check("sft_pulses", sft_cnt, N);
                    check("lda_pulses", lda_cnt, 0);
                end
                $display("txn: done at edge %0d product %h sft=%0d ldA=%0d",
                         edges, {a_reg[15:0], q_reg}, sft_cnt, lda_cnt);
            end
        end
        prev_cnt  = cnt;
        prev_busy = busy;
        prev_ldq  = ldQ;
    end

    // Stimulus helpers
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_edges(input int target);
        while (edges < target) tick();
    endtask

    task automatic push_exp(input int edge_no, input logic [31:0] prod,
                            input bit cp, input bit cc);
        exp_t e;
        e.edge_no    = edge_no;
        e.prod       = prod;
        e.chk_prod   = cp;
        e.chk_counts = cc;
        sb.push_back(e);
    endtask

    // Start a run from IDLE; returns k = edge count of the sampling edge,
    // leaving the bench just after the edge that enters EVAL (edge k+2).
    task automatic run(input logic [15:0] mv, input logic [15:0] qv,
                       input logic [31:0] prod, input bit cp, input bit cc,
                       output int k);
        start = 1'b1;
        tick();
        k     = edges;
        start = 1'b0;
        push_exp(k + 2 + 2 * N, prod, cp, cc);
        bus = mv;
        tick();
        bus = qv;
        tick();
    endtask

    task automatic chk_idle(input string tag);
        @(negedge clk);
        check({tag, "_strobes"}, {23'd0, ldM, ldQ, clrA, clrff, ldA, addsub, sft, busy, done}, 32'd0);
        check({tag, "_cnt"}, {{(32-CW){1'b0}}, cnt}, 32'd0);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog got timeout required $finish");
        $fatal(1);
    end

    initial begin
        int k;
        int k2;
        rst = 1'b1; start = 1'b0; bus = '0;
        ovr = 1'b0; ovr_q0 = 1'b0; ovr_qm1 = 1'b0;
        tick(); tick();
        chk_idle("reset");
        // reset wins over start
        start = 1'b1;
        tick();
        chk_idle("rst_prio");
        start = 1'b0;
        rst   = 1'b0;
        tick(); tick();

        // q0=qm1=0 throughout: no ldA, 16 shifts
        ovr = 1'b1; ovr_q0 = 1'b0; ovr_qm1 = 1'b0;
        run(16'd7, 16'd3, 32'd0, 1'b0, 1'b1, k);
        wait_edges(k + 3 + 2 * N);
        tick();

        // Mealy decode per EVAL, with start re-pulsed mid-run
        run(16'd7, 16'd3, 32'd0, 1'b0, 1'b0, k);
        ovr_q0 = 1'b1; ovr_qm1 = 1'b0;
        @(negedge clk);
        check("eval10_ldA", {31'd0, ldA}, 32'd1);
        check("eval10_addsub", {31'd0, addsub}, 32'd0);
        tick();
        ovr_q0 = 1'b0; ovr_qm1 = 1'b0; start = 1'b1;
        tick();
        start = 1'b0; ovr_q0 = 1'b0; ovr_qm1 = 1'b1;
        @(negedge clk);
        check("eval01_ldA", {31'd0, ldA}, 32'd1);
        check("eval01_addsub", {31'd0, addsub}, 32'd1);
        tick();
        start = 1'b1; ovr_q0 = 1'b0; ovr_qm1 = 1'b0;
        tick();
        start = 1'b0; ovr_q0 = 1'b1; ovr_qm1 = 1'b1;
        @(negedge clk);
        check("eval11_ldA", {31'd0, ldA}, 32'd0);
        tick();
        ovr_q0 = 1'b0; ovr_qm1 = 1'b0;
        wait_edges(k + 3 + 2 * N);
        ovr = 1'b0;
        tick();

        // Closed-loop products
        run(16'd7, 16'hFFFD, 32'hFFFFFFEB, 1'b1, 1'b0, k);
        wait_edges(k + 3 + 2 * N);
        tick();
        run(16'h8000, 16'h8000, 32'h40000000, 1'b1, 1'b0, k);
        wait_edges(k + 3 + 2 * N);
        tick();

        // Reset in the middle of a run, then a full run
        run(16'd5, 16'd5, 32'd25, 1'b1, 1'b0, k);
        wait_edges(k + 9);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        void'(sb.pop_back());
        chk_idle("mid_rst");
        tick();
        run(16'd3, 16'd5, 32'h0000000F, 1'b1, 1'b0, k);
        wait_edges(k + 3 + 2 * N);
        tick();

        // start held high: back-to-back runs, second LOAD_M 2 cycles after done
        bus   = 16'd9;
        start = 1'b1;
        tick();
        k  = edges;
        k2 = k + 2 + 2 * N + 2;
        push_exp(k + 2 + 2 * N, 32'h00000051, 1'b1, 1'b0);
        push_exp(k2 + 2 + 2 * N, 32'h00000051, 1'b1, 1'b0);
        wait_edges(k2);
        start = 1'b0;
        @(negedge clk);
        check("second_ldM", {31'd0, ldM}, 32'd1);
        wait_edges(k2 + 3 + 2 * N);
        tick(); tick(); tick();

        check("sb_empty", sb.size(), 32'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/booth_ctrl.md
BOOTH_CTRL -- requirements
Module: booth_ctrl

Interface
REQ-001 Parameter N, default 16, operand width in bits and number of Booth iterations.
REQ-002 clk  input  1  rising-edge clock for all state.
REQ-003 rst  input  1  synchronous reset, active-high.
REQ-004 start  input  1  begin request; sampled only in IDLE.
REQ-005 q0  input  1  LSB of datapath Q register.
REQ-006 qm1  input  1  datapath Q[-1] flop.
REQ-007 ldM  output  1  load multiplicand register from the shared operand bus.
REQ-008 ldQ  output  1  load multiplier register from the shared operand bus.
REQ-009 clrA  output  1  clear accumulator A.
REQ-010 clrff  output  1  clear Q[-1] flop.
REQ-011 ldA  output  1  load A with adder/subtractor result.
REQ-012 addsub  output  1  1 = A+M, 0 = A-M; meaningful only while ldA=1.
REQ-013 sft  output  1  arithmetic right shift of {A,Q,Q[-1]}.
REQ-014 busy  output  1  high in every state except IDLE.
REQ-015 done  output  1  one-cycle completion pulse.
REQ-016 cnt  output  $clog2(N)+1  remaining iteration count.

Function
REQ-017 States: IDLE, LOAD_M, LOAD_Q, EVAL, SHIFT, DONE.
REQ-018 IDLE: start=1 -> LOAD_M; else stay; all strobes 0.
REQ-019 LOAD_M: ldM=1, clrA=1, clrff=1 for one cycle -> LOAD_Q; host presents multiplicand on the bus during this cycle.
REQ-020 LOAD_Q: ldQ=1 for one cycle; cnt<=N on the exit edge -> EVAL; host presents multiplier on the bus during this cycle.
REQ-021 EVAL, one cycle: {q0,qm1}=2'b10 -> ldA=1, addsub=0; 2'b01 -> ldA=1, addsub=1; 2'b00/2'b11 -> ldA=0; always -> SHIFT.
REQ-022 ldA/addsub are Mealy (combinational from state, q0, qm1); all other strobes are Moore (decoded from state only).
REQ-023 SHIFT: sft=1; cnt<=cnt-1 on the exit edge; if cnt==1 in SHIFT -> DONE, else -> EVAL.
REQ-024 DONE: done=1 for exactly one cycle -> IDLE.
REQ-025 Fixed latency: start sampled in IDLE at edge k -> LOAD_M at cycle k+1; done at cycle k+3+2N (k+35 for N=16); busy high cycles k+1..k+3+2N.
REQ-026 No more than one of ldM, ldQ, ldA, sft is asserted in any cycle.
REQ-027 start while busy=1 is ignored; no restart or abort.
REQ-028 start held high continuously -> DONE, one IDLE cycle, then a new run.
REQ-029 cnt never wraps; it reaches 0 exactly at entry to DONE and holds 0 in IDLE.

Reset
REQ-030 rst=1 at any edge, including mid-operation -> next cycle state=IDLE, cnt=0, all outputs 0; rst has priority over start.
REQ-031 Reset values: ldM=ldQ=clrA=clrff=ldA=addsub=sft=busy=done=0, cnt=0.

Verification
REQ-032 Run with q0=qm1=0 throughout, start pulsed at cycle 0 -> 16 EVAL cycles, ldA never 1, 16 sft pulses, done=1 at cycle 35 only.
REQ-033 EVAL with {q0,qm1}=10 -> ldA=1, addsub=0; with 01 -> ldA=1, addsub=1; with 11 -> ldA=0, same cycle.
REQ-034 Closed loop with a behavioural 16-bit PIPO/shift datapath, M=16'd7, Q=16'hFFFD -> {A,Q}=32'hFFFFFFEB at done; M=16'h8000, Q=16'h8000 -> 32'h40000000.
REQ-035 rst asserted at cycle 10 of a run -> cycle 11 busy=0, cnt=0, all strobes 0; a later start runs the full 35-cycle sequence.
REQ-036 start re-pulsed during EVAL/SHIFT -> ignored, done timing unchanged; start held high -> second LOAD_M exactly 2 cycles after done.
REQ-037 Every cycle: one-hot check of {ldM,ldQ,ldA,sft}; cnt monotonically non-increasing within a run.
